// File: rtl/osd_uart_nasti_reader.sv
// rtl/osd_uart_nasti_reader.sv - NASTI-lite initiator that configures a 16550 UART and drains its receive path
module osd_uart_nasti_reader #(
  parameter logic [15:0] DIVISOR  = 16'h00de,
  parameter logic [7:0]  LCR_VAL  = 8'h03,
  parameter int          POLL_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] aw_addr,
  output logic       aw_valid,
  input  logic       aw_ready,
  output logic [7:0] w_data,
  output logic       w_valid,
  input  logic       w_ready,
  input  logic [1:0] b_resp,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [2:0] ar_addr,
  output logic       ar_valid,
  input  logic       ar_ready,
  input  logic [7:0] r_data,
  input  logic [1:0] r_resp,
  input  logic       r_valid,
  output logic       r_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       init_done,
  output logic       err
);

  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_LSR = 3'd5;

  // GAP counts down to zero inclusive, so it is loaded with one less than the idle length
  localparam int         GAP_M1   = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [7:0] GAP_LOAD = GAP_M1[7:0];

  typedef enum logic [3:0] {
    W_LCR_DLAB,
    W_DLL,
    W_DLM,
    W_LCR,
    POLL_AR,
    POLL_R,
    GAP,
    DATA_AR,
    DATA_R,
    DELIVER
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // r_armed keeps every valid low in the first cycle after reset so outputs hold reset values
  logic       r_armed;
  logic       r_aw_done;
  logic       r_w_done;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_out_data;
  logic       r_init_done;
  logic       r_err;

  logic       w_is_write;
  logic [2:0] w_wr_addr;
  logic [7:0] w_wr_data;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_r_ok;

  // Address/data of the configuration write owned by the current state
  always_comb begin
    w_is_write = 1'b0;
    w_wr_addr  = 3'd0;
    w_wr_data  = 8'd0;
    case (r_state)
      W_LCR_DLAB: begin w_is_write = 1'b1; w_wr_addr = ADDR_LCR; w_wr_data = 8'h80;          end
      W_DLL:      begin w_is_write = 1'b1; w_wr_addr = ADDR_RBR; w_wr_data = DIVISOR[7:0];   end
      W_DLM:      begin w_is_write = 1'b1; w_wr_addr = ADDR_DLM; w_wr_data = DIVISOR[15:8];  end
      W_LCR:      begin w_is_write = 1'b1; w_wr_addr = ADDR_LCR; w_wr_data = LCR_VAL;        end
      default:    begin w_is_write = 1'b0; w_wr_addr = 3'd0;     w_wr_data = 8'd0;           end
    endcase
  end

  // Bus outputs decoded from registered state only; no input reaches an output combinationally
  always_comb begin
    aw_valid  = w_is_write & r_armed & ~r_aw_done;
    w_valid   = w_is_write & r_armed & ~r_w_done;
    b_ready   = w_is_write & r_aw_done & r_w_done;
    aw_addr   = aw_valid ? w_wr_addr : 3'd0;
    w_data    = w_valid ? w_wr_data : 8'd0;
    ar_valid  = r_armed & ((r_state == POLL_AR) | (r_state == DATA_AR));
    ar_addr   = (ar_valid && r_state == POLL_AR) ? ADDR_LSR : 3'd0;
    r_ready   = (r_state == POLL_R) | (r_state == DATA_R);
    out_valid = (r_state == DELIVER);
    out_data  = r_out_data;
    init_done = r_init_done;
    err       = r_err;

    w_aw_hs   = aw_valid & aw_ready;
    w_w_hs    = w_valid & w_ready;
    w_b_hs    = b_ready & b_valid;
    w_ar_hs   = ar_valid & ar_ready;
    w_r_hs    = r_ready & r_valid;
    w_r_ok    = (r_resp == 2'b00);
  end

  // Next-state: four writes, then poll LSR.DR and fetch RBR when data is waiting
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_LCR_DLAB: if (w_b_hs) w_state_nxt = W_DLL;
      W_DLL:      if (w_b_hs) w_state_nxt = W_DLM;
      W_DLM:      if (w_b_hs) w_state_nxt = W_LCR;
      W_LCR:      if (w_b_hs) w_state_nxt = POLL_AR;
      POLL_AR:    if (w_ar_hs) w_state_nxt = POLL_R;
      POLL_R: begin
        if (w_r_hs) begin
          if (w_r_ok && r_data[0]) begin
            w_state_nxt = DATA_AR;
          end else if (POLL_GAP == 0) begin
            w_state_nxt = POLL_AR;
          end else begin
            w_state_nxt = GAP;
          end
        end
      end
      GAP:        if (r_gap_cnt == 8'd0) w_state_nxt = POLL_AR;
      DATA_AR:    if (w_ar_hs) w_state_nxt = DATA_R;
      DATA_R: begin
        if (w_r_hs) begin
          w_state_nxt = w_r_ok ? DELIVER : POLL_AR;
        end
      end
      DELIVER:    if (out_ready) w_state_nxt = POLL_AR;
      default:    w_state_nxt = W_LCR_DLAB;
    endcase
  end

  // State register; reset restarts the configuration sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= W_LCR_DLAB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake bookkeeping, poll gap timer, captured byte and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_gap_cnt   <= 8'd0;
      r_out_data  <= 8'd0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_armed <= 1'b1;

      if (w_b_hs) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (r_state == POLL_R && w_state_nxt == GAP) begin
        r_gap_cnt <= GAP_LOAD;
      end else if (r_state == GAP && r_gap_cnt != 8'd0) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end

      if (r_state == DATA_R && w_r_hs && w_r_ok) begin
        r_out_data <= r_data;
      end

      if (r_state == W_LCR && w_b_hs) begin
        r_init_done <= 1'b1;
      end

      if ((w_b_hs && b_resp != 2'b00) || (w_r_hs && !w_r_ok)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_uart_nasti_reader.sv
// tb/tb_osd_uart_nasti_reader.sv - self-checking bench for osd_uart_nasti_reader
module tb_osd_uart_nasti_reader;

  localparam int POLL_GAP = 4;
  localparam int LIMIT    = 60;

  logic       clk;
  logic       rst;
  logic [2:0] aw_addr;
  logic       aw_valid;
  logic       aw_ready;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready;
  logic [1:0] b_resp;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] ar_addr;
  logic       ar_valid;
  logic       ar_ready;
  logic [7:0] r_data;
  logic [1:0] r_resp;
  logic       r_valid;
  logic       r_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       init_done;
  logic       err;

  osd_uart_nasti_reader #(
    .DIVISOR (16'h00de),
    .LCR_VAL (8'h03),
    .POLL_GAP(POLL_GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .aw_addr  (aw_addr),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ar_addr  (ar_addr),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .init_done(init_done),
    .err      (err)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         aw_d;
    int         w_d;
    int         b_d;
  } wr_vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [1:0] resp;
    int         gap;
    bit         deliver;
    int         stall;
  } rd_vec_t;

  int      n_chk;
  int      n_pass;
  logic    m_err;
  wr_vec_t wr_tab[4];
  rd_vec_t rd_tab[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_resp    = 2'b00;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_resp    = 2'b00;
    r_data    = 8'h00;
    out_ready = 1'b0;
  endtask

  task automatic wait_write();
    int n;
    n = 0;
    @(negedge clk); idle_inputs();
    while (!(aw_valid || w_valid) && n < LIMIT) begin
      @(negedge clk); idle_inputs();
      n++;
    end
    chk("write_wait_bound", n < LIMIT, 1);
  endtask

  // Counts idle cycles before the next AR; stray responses are offered while nothing is outstanding
  task automatic wait_ar(output int n);
    n = 0;
    @(negedge clk); idle_inputs();
    while (!ar_valid && n < LIMIT) begin
      r_valid = 1'b1; r_resp = 2'b11; r_data = 8'hff;
      b_valid = 1'b1; b_resp = 2'b11;
      @(negedge clk); idle_inputs();
      n++;
    end
    chk("ar_wait_bound", n < LIMIT, 1);
  endtask

  task automatic do_write(input logic [2:0] ea, input logic [7:0] ed,
                          input int aw_d, input int w_d, input int b_d, input logic [1:0] br);
    int m;
    m = (aw_d > w_d) ? aw_d : w_d;
    wait_write();
    for (int k = 0; k <= m; k++) begin
      if (k > 0) begin @(negedge clk); idle_inputs(); end
      chk("aw_valid", aw_valid, (k <= aw_d));
      chk("w_valid", w_valid, (k <= w_d));
      chk("b_ready_early", b_ready, 0);
      chk("ar_valid_during_write", ar_valid, 0);
      if (aw_valid) chk("aw_addr", aw_addr, ea);
      if (w_valid)  chk("w_data", w_data, ed);
      aw_ready = (k == aw_d);
      w_ready  = (k == w_d);
      b_valid  = 1'b1; b_resp = 2'b11;
      r_valid  = 1'b1; r_resp = 2'b11;
    end
    for (int j = 0; j <= b_d; j++) begin
      @(negedge clk); idle_inputs();
      chk("b_ready", b_ready, 1);
      chk("valids_after_hs", {aw_valid, w_valid}, 0);
      if (j == 0) chk("init_done_early", init_done, 0);
      if (j == b_d) begin b_valid = 1'b1; b_resp = br; end
    end
  endtask

  task automatic do_read(input logic [2:0] ea, input logic [7:0] rd, input logic [1:0] rr,
                         input int ar_d, input int r_d, input int exp_gap);
    int n;
    wait_ar(n);
    chk("poll_gap", n, exp_gap);
    chk("out_valid_idle", out_valid, 0);
    chk("err", err, m_err);
    chk("init_done", init_done, 1);
    for (int k = 0; k <= ar_d; k++) begin
      if (k > 0) begin @(negedge clk); idle_inputs(); end
      chk("ar_valid", ar_valid, 1);
      chk("ar_addr", ar_addr, ea);
      chk("r_ready_early", r_ready, 0);
      chk("aw_valid_during_read", aw_valid, 0);
      ar_ready = (k == ar_d);
    end
    for (int j = 0; j <= r_d; j++) begin
      @(negedge clk); idle_inputs();
      chk("r_ready", r_ready, 1);
      chk("ar_valid_after_hs", ar_valid, 0);
      if (j == r_d) begin
        r_valid = 1'b1; r_data = rd; r_resp = rr;
      end else begin
        r_data = ~rd;
      end
    end
  endtask

  task automatic do_deliver(input logic [7:0] ed, input int stall);
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk); idle_inputs();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, ed);
      chk("ar_valid_in_stall", ar_valid, 0);
      if (k == 0) chk("err_at_deliver", err, m_err);
      out_ready = (k == stall);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_valids", {aw_valid, w_valid, ar_valid, out_valid}, 0);
    chk("rst_readies", {b_ready, r_ready}, 0);
    chk("rst_status", {init_done, err}, 0);
    chk("rst_addr_data", {aw_addr, w_data, ar_addr, out_data}, 0);
  endtask

  initial begin
    int         n;
    logic       want_data;
    int         gap;
    logic [7:0] rd;
    logic [1:0] rr;
    logic [1:0] br;

    n_chk  = 0;
    n_pass = 0;
    m_err  = 1'b0;

    wr_tab[0] = '{3'd3, 8'h80, 0, 0, 0};
    wr_tab[1] = '{3'd0, 8'hde, 3, 0, 1};
    wr_tab[2] = '{3'd1, 8'h00, 0, 3, 0};
    wr_tab[3] = '{3'd3, 8'h03, 2, 2, 2};

    rd_tab[0]  = '{3'd5, 8'h60, 2'b00, 0,        1'b0, 0};
    rd_tab[1]  = '{3'd5, 8'h60, 2'b00, POLL_GAP, 1'b0, 0};
    rd_tab[2]  = '{3'd5, 8'h61, 2'b00, POLL_GAP, 1'b0, 0};
    rd_tab[3]  = '{3'd0, 8'h48, 2'b00, 0,        1'b1, 10};
    rd_tab[4]  = '{3'd5, 8'h61, 2'b00, 0,        1'b0, 0};
    rd_tab[5]  = '{3'd0, 8'h33, 2'b10, 0,        1'b0, 0};
    rd_tab[6]  = '{3'd5, 8'h60, 2'b00, 0,        1'b0, 0};
    rd_tab[7]  = '{3'd5, 8'h61, 2'b00, POLL_GAP, 1'b0, 0};
    rd_tab[8]  = '{3'd0, 8'h65, 2'b00, 0,        1'b1, 0};
    rd_tab[9]  = '{3'd5, 8'h61, 2'b10, 0,        1'b0, 0};
    rd_tab[10] = '{3'd5, 8'h61, 2'b00, POLL_GAP, 1'b0, 0};
    rd_tab[11] = '{3'd0, 8'h21, 2'b00, 0,        1'b1, 2};

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk_reset_values();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].aw_d, wr_tab[i].w_d, wr_tab[i].b_d, 2'b00);
    end

    for (int i = 0; i < 12; i++) begin
      do_read(rd_tab[i].addr, rd_tab[i].data, rd_tab[i].resp, i % 2, (i / 2) % 3, rd_tab[i].gap);
      if (rd_tab[i].resp != 2'b00) m_err = 1'b1;
      if (rd_tab[i].deliver) do_deliver(rd_tab[i].data, rd_tab[i].stall);
    end

    // Reset while a poll waits for its R beat
    wait_ar(n);
    chk("pre_reset_poll_gap", n, 0);
    chk("pre_reset_ar_addr", ar_addr, 5);
    ar_ready = 1'b1;
    @(negedge clk); idle_inputs();
    chk("pre_reset_r_ready", r_ready, 1);
    chk("pre_reset_err", err, 1);
    rst = 1'b1;
    @(negedge clk); idle_inputs();
    chk_reset_values();
    rst   = 1'b0;
    m_err = 1'b0;

    // Re-initialisation with random skew and random B errors, then random polling
    for (int i = 0; i < 4; i++) begin
      br = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      do_write(wr_tab[i].addr, wr_tab[i].data, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), br);
      if (br != 2'b00) m_err = 1'b1;
    end

    want_data = 1'b0;
    gap       = 0;
    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom);
      rr = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      do_read(want_data ? 3'd0 : 3'd5, rd, rr, $urandom_range(0, 2), $urandom_range(0, 2), gap);
      if (rr != 2'b00) m_err = 1'b1;
      if (want_data) begin
        if (rr == 2'b00) do_deliver(rd, $urandom_range(0, 3));
        want_data = 1'b0;
        gap       = 0;
      end else if (rr == 2'b00 && rd[0]) begin
        want_data = 1'b1;
        gap       = 0;
      end else begin
        gap = POLL_GAP;
      end
    end

    @(negedge clk); idle_inputs();
    chk("final_err", err, m_err);
    chk("final_init_done", init_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/osd_uart_nasti_reader.md
Name: osd_uart_nasti_reader

Overview:
- NASTI-lite (AXI-lite subset, 3-bit address, 8-bit data) initiator for the receive side of the 16550-compatible debug UART register interface.
- After reset it programs divisor and line control once. It then polls LSR.DR (addr 5, bit 0) and, when set, reads RBR (addr 0).
- Each received byte is delivered on a valid/ready byte stream.
- Sits in system/bench logic as the consumer counterpart to the host-to-device path of osd_dem_uart_nasti.

Parameters:
- DIVISOR, 16'h00de: divisor latch value; DLL = DIVISOR[7:0] at addr 0, DLM = DIVISOR[15:8] at addr 1.
- LCR_VAL, 8'h03: final LCR value (8N1); bit 7 must be 0.
- POLL_GAP, 4: idle cycles between an LSR read with DR=0 and the next poll; legal range 0..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aw_addr  out  3  write address
- aw_valid  out  1  write address valid
- aw_ready  in  1  write address ready
- w_data  out  8  write data
- w_valid  out  1  write data valid
- w_ready  in  1  write data ready
- b_resp  in  2  write response
- b_valid  in  1  write response valid
- b_ready  out  1  write response ready
- ar_addr  out  3  read address
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address ready
- r_data  in  8  read data
- r_resp  in  2  read response
- r_valid  in  1  read response valid
- r_ready  out  1  read response ready
- out_data  out  8  received byte
- out_valid  out  1  byte valid
- out_ready  in  1  consumer ready
- init_done  out  1  configuration complete, sticky until reset
- err  out  1  sticky, set by any resp != 2'b00

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values: all valid outputs = 0, b_ready = 0, r_ready = 0, init_done = 0, err = 0, out_data = 0. Address and data outputs are 0.
- Reset mid-transaction abandons the transaction immediately. Restart begins in state W_LCR_DLAB.
- Write states (one write each, in order):
  - W_LCR_DLAB: addr 3, data 8'h80.
  - W_DLL: addr 0, data DIVISOR[7:0].
  - W_DLM: addr 1, data DIVISOR[15:8].
  - W_LCR: addr 3, data LCR_VAL.
- Write handshake:
  - aw_valid and w_valid assert together on state entry.
  - Each one drops in the cycle after its own handshake. They may complete in different cycles, in either order, or simultaneously.
  - Address and data stay stable while their valid is high.
  - After both handshakes, b_ready = 1 until b_valid. Then advance to the next write state.
  - b_ready is never high before both AW and W have completed.
  - b_resp != 0 sets err; the sequence continues regardless.
- Initialisation complete: after the W_LCR response, init_done = 1 (registered) and the FSM enters POLL_AR.
- Read states:
  - POLL_AR: ar_valid = 1, ar_addr = 5, held stable until ar_ready. Then go to POLL_R.
  - POLL_R: r_ready = 1 until r_valid.
    - r_resp != 0: set err, treat as DR = 0.
    - DR (r_data[0]) = 1: go to DATA_AR.
    - DR = 0: go to GAP, or to POLL_AR directly if POLL_GAP = 0.
  - GAP: 8-bit counter loaded with POLL_GAP-1, decrements to 0, then go to POLL_AR. The first poll after init has no gap.
  - DATA_AR: ar_addr = 0, same AR rules as POLL_AR.
  - DATA_R: r_ready = 1 until r_valid.
    - r_resp = 0: capture r_data into out_data, set out_valid, go to DELIVER.
    - Error: set err, discard the byte, go to POLL_AR.
  - DELIVER: out_valid held and out_data stable until out_ready. In the handshake cycle, go to POLL_AR. out_valid clears the next cycle.
- No bus activity in DELIVER: a stalled consumer back-pressures the UART.
- Exclusivity:
  - At most one outstanding transaction at any time.
  - AR is never issued while a write is pending.
  - r_ready and b_ready are low outside their wait states. Stray r_valid/b_valid in other states is ignored.
- Minimum latencies:
  - AR to R with a ready slave: 1 cycle.
  - LSR DR=1 to out_valid: 2 cycles plus slave latency.
  - out_valid does not depend combinationally on out_ready.

Test Plan:
- Reset then init with an always-ready slave: observe four writes, in order (3, 8'h80), (0, 8'hde), (1, 8'h00), (3, 8'h03). Each has b_ready only after both handshakes. init_done rises 1 cycle after the 4th B handshake.
- Skewed write handshake, w_ready 3 cycles before aw_ready: w_valid drops after the W handshake and aw_valid stays high until the AW handshake. No B accepted early. Same check with aw_ready first.
- Slave returns LSR = 8'h60 twice, then 8'h61, with RBR = 8'h48: two polls separated by 4 idle cycles. Then an addr 0 read and out_data = 8'h48 with out_valid.
- out_ready held low 10 cycles: out_valid and out_data = 8'h48 stable, no ar_valid during the stall. A poll is issued in the cycle after the handshake.
- RBR read returns r_resp = 2'b10: err = 1, no out_valid, polling resumes. A later good byte 8'h65 is still delivered and err stays 1.
- rst asserted while waiting for R during a poll: all outputs at reset values the next cycle. Init write (3, 8'h80) is reissued.
